// File: rtl/cmp_bist_checker.sv
// Exhaustive self-checking sequencer for a 2-operand magnitude comparator (F = A > B).
// Walks every {A,B} in ascending order, waits SETTLE cycles per vector, samples F
// and compares against an internal unsigned A > B. Reports error count, first
// failing vector and a pass flag once the sweep is complete.
module cmp_bist_checker #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   A,
    output logic [WIDTH-1:0]   B,
    input  logic               F,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic [2*WIDTH-1:0] first_fail
);
    localparam int VW = 2 * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_APPLY, S_WAIT, S_CHECK, S_DONE
    } state_t;

    state_t          state_q;
    logic [VW-1:0]   vec_q;
    logic [3:0]      cnt_q;
    logic [VW:0]     err_q;
    logic [VW-1:0]   ff_q;
    logic            seen_q;
    logic            busy_q, done_q, pass_q;

    logic            expected_d;
    logic            mism_d;

    // Reference result and mismatch flag for the vector currently on A/B;
    // only consumed in CHECK so an unknown F elsewhere is harmless.
    always_comb begin
        expected_d = vec_q[VW-1:WIDTH] > vec_q[WIDTH-1:0];
        mism_d     = (F != expected_d);
    end

    // Sweep FSM; status flags are registered alongside the state so they are
    // glitch-free and change on the same edge as the state transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            seen_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        vec_q   <= '0;
                        err_q   <= '0;
                        ff_q    <= '0;
                        seen_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        state_q <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    cnt_q <= 4'(SETTLE);
                    if (SETTLE > 0) state_q <= S_WAIT;
                    else            state_q <= S_CHECK;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) state_q <= S_CHECK;
                end
                S_CHECK: begin
                    if (mism_d) begin
                        err_q <= err_q + (VW+1)'(1);
                        if (!seen_q) begin
                            ff_q   <= vec_q;
                            seen_q <= 1'b1;
                        end
                    end
                    if (&vec_q) begin
                        // Last vector: fold this check's outcome into pass directly.
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_q == '0) && !mism_d;
                        state_q <= S_DONE;
                    end else begin
                        vec_q   <= vec_q + VW'(1);
                        state_q <= S_APPLY;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign A          = vec_q[VW-1:WIDTH];
    assign B          = vec_q[WIDTH-1:0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_cmp_bist_checker.sv
// Directed bench: two checkers (SETTLE=1 and SETTLE=0) each driven by a small
// behavioural comparator whose fault mode is selected per scenario.
module tb_cmp_bist_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // SETTLE = 1 instance
    logic       start1 = 1'b0, F1, busy1, done1, pass1;
    logic [1:0] A1, B1;
    logic [4:0] err1;
    logic [3:0] ff1;
    int         mode1 = 0;
    // SETTLE = 0 instance
    logic       start0 = 1'b0, F0, busy0, done0, pass0;
    logic [1:0] A0, B0;
    logic [4:0] err0;
    logic [3:0] ff0;
    int         mode0 = 0;

    cmp_bist_checker #(.WIDTH(2), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .A(A1), .B(B1), .F(F1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_fail(ff1));
    cmp_bist_checker #(.WIDTH(2), .SETTLE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .A(A0), .B(B0), .F(F0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_fail(ff0));

    // Comparator under test: 0 golden, 1 stuck-at-0, 2 stuck-at-1, 3 A<B
    function automatic logic fmodel(input int m, input logic [1:0] a, input logic [1:0] b);
        case (m)
            0:       return a > b;
            1:       return 1'b0;
            2:       return 1'b1;
            default: return a < b;
        endcase
    endfunction

    always_comb F1 = fmodel(mode1, A1, B1);
    always_comb F0 = fmodel(mode0, A0, B0);

    // Muxed view of the selected instance so one sweep task serves both
    logic       sel = 1'b0;
    logic       busy_m, done_m, pass_m;
    logic [3:0] ab_m, ff_m;
    logic [4:0] err_m;
    always_comb begin
        busy_m = sel ? busy0 : busy1;
        done_m = sel ? done0 : done1;
        pass_m = sel ? pass0 : pass1;
        ab_m   = sel ? {A0, B0} : {A1, B1};
        ff_m   = sel ? ff0 : ff1;
        err_m  = sel ? err0 : err1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full sweep on the selected instance; start is pulsed for one cycle.
    task automatic sweep(input string tag, input int exp_edges, input int per_vec,
                         input int exp_err, input logic [3:0] exp_ff, input logic exp_pass);
        int k = 0;
        int seq_bad = 0;
        @(negedge clk);
        if (sel) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        chk({tag, "_busy_after_start"}, 32'(busy_m), 32'd1);
        chk({tag, "_done_dropped"}, 32'(done_m), 32'd0);
        while (!done_m && k < 200) begin
            @(negedge clk);
            k++;
            if (!done_m && ab_m != 4'(k / per_vec)) seq_bad++;
        end
        chk({tag, "_done_edge"}, 32'(k), 32'(exp_edges));
        chk({tag, "_ab_sequence_errs"}, 32'(seq_bad), 32'd0);
        chk({tag, "_err_count"}, 32'(err_m), 32'(exp_err));
        chk({tag, "_first_fail"}, 32'(ff_m), 32'(exp_ff));
        chk({tag, "_pass"}, 32'(pass_m), 32'(exp_pass));
        chk({tag, "_busy_low"}, 32'(busy_m), 32'd0);
        repeat (3) @(negedge clk);
        chk({tag, "_held"}, {25'd0, done_m, err_m, ff_m[0]}, {25'd0, 1'b1, 5'(exp_err), exp_ff[0]});
    endtask

    initial begin
        // Reset state
        #3;
        chk("reset1", {20'd0, busy1, done1, pass1, err1, ff1, A1, B1}, 32'd0);
        chk("reset0", {20'd0, busy0, done0, pass0, err0, ff0, A0, B0}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_start", {29'd0, busy1, done1, pass1}, 32'd0);

        // Scenarios 1-4 on the SETTLE=1 instance
        sel = 1'b0;
        mode1 = 0; sweep("golden", 48, 3, 0, 4'b0000, 1'b1);
        mode1 = 1; sweep("stuck0", 48, 3, 6, 4'b0100, 1'b0);
        mode1 = 2; sweep("stuck1", 48, 3, 10, 4'b0000, 1'b0);
        mode1 = 3; sweep("lessthan", 48, 3, 12, 4'b0001, 1'b0);

        // Scenario 5: mid-sweep start ignored, then async reset at vector 7
        mode1 = 0;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;          // after start edge (k=0)
        repeat (9) @(negedge clk);               // k=9, vector 3
        chk("mid_vec3", 32'({A1, B1}), 32'd3);
        start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;           // k=10
        repeat (2) @(negedge clk);               // k=12
        chk("mid_start_ignored", 32'({A1, B1}), 32'd4);
        chk("mid_busy", 32'(busy1), 32'd1);
        repeat (9) @(negedge clk);               // k=21, vector 7
        chk("at_vec7", 32'({A1, B1}), 32'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {20'd0, busy1, done1, pass1, err1, ff1, A1, B1}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("after_reset_idle", {26'd0, busy1, done1, A1, B1}, 32'd0);
        sweep("fresh", 48, 3, 0, 4'b0000, 1'b1);

        // Scenario 6: SETTLE=0, stuck-at-0 then golden clears results
        sel = 1'b1;
        mode0 = 1; sweep("s0_stuck0", 32, 2, 6, 4'b0100, 1'b0);
        mode0 = 0; sweep("s0_golden", 32, 2, 0, 4'b0000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
